// File: rtl/si_arith_pkg.sv
// Shared helpers for the signed quantized-arithmetic datapath: saturation,
// rounding constant, and the default requantization multiplier.
package si_arith_pkg;

  localparam int unsigned MAX_W = 128;
  localparam logic [31:0] M0_DEFAULT    = 32'd1932735283;
  localparam int unsigned SHIFT_DEFAULT = 10;

  // Clamp a sign-extended value to the signed range of a w-bit word.
  function automatic logic signed [MAX_W-1:0] sat_to(input logic signed [MAX_W-1:0] x,
                                                      input int unsigned w);
    logic signed [MAX_W-1:0] mx;
    logic signed [MAX_W-1:0] mn;
    mx = (MAX_W'(1) << (w - 1)) - MAX_W'(1);
    mn = ~mx;
    if (x > mx)      sat_to = mx;
    else if (x < mn) sat_to = mn;
    else             sat_to = x;
  endfunction

  // Half-LSB of the final result, added before the arithmetic right shift.
  function automatic logic [MAX_W-1:0] round_const(input int unsigned shift);
    round_const = MAX_W'(1) << (31 + shift);
  endfunction

endpackage

// File: rtl/si_requant.sv
// Combinational downscale: x * M0 / 2^(32+SHIFT), round-half-up, saturate to N_OUT.
module si_requant
  import si_arith_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned N_OUT   = 8,
  parameter logic [31:0] M0_0Q32 = M0_DEFAULT,
  parameter int unsigned SHIFT   = SHIFT_DEFAULT
) (
  input  logic signed [N-1:0]     x,
  output logic signed [N_OUT-1:0] q
);

  localparam int unsigned PW = N + 33;
  localparam int unsigned SW = PW + 1;

  logic signed [PW-1:0] x_ext;
  logic signed [PW-1:0] m_ext;
  logic signed [PW-1:0] p;
  logic signed [SW-1:0] biased;
  logic signed [SW-1:0] r;

  always_comb begin
    x_ext  = PW'(x);
    m_ext  = PW'($signed({1'b0, M0_0Q32}));
    p      = x_ext * m_ext;
    biased = SW'(p) + $signed(SW'(round_const(SHIFT)));
    r      = biased >>> (32 + SHIFT);
    q      = N_OUT'(sat_to(MAX_W'(r), N_OUT));
  end

endmodule

// File: rtl/si_quant_arith.sv
// Two-stage signed MAC datapath: saturating multiply/accumulate, then requantize.
module si_quant_arith
  import si_arith_pkg::*;
#(
  parameter int unsigned N       = 32,
  parameter int unsigned N_OUT   = 8,
  parameter logic [31:0] M0_0Q32 = M0_DEFAULT,
  parameter int unsigned SHIFT   = SHIFT_DEFAULT
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  input  logic signed [N-1:0]     a,
  input  logic signed [N-1:0]     b,
  input  logic signed [N-1:0]     c,
  output logic signed [N-1:0]     mpy_out,
  output logic signed [N-1:0]     add_out,
  output logic                    s1_valid,
  output logic signed [N_OUT-1:0] q_out,
  output logic                    s2_valid
);

  localparam int unsigned PRW = 2 * N;
  localparam int unsigned SMW = N + 1;

  if (SHIFT > 31 || N_OUT > N) begin : g_bad_params
    $error("si_quant_arith: illegal SHIFT or N_OUT");
  end

  logic signed [PRW-1:0]   prod;
  logic signed [N-1:0]     mpy_sat;
  logic signed [SMW-1:0]   sum;
  logic signed [N-1:0]     add_sat;
  logic signed [N_OUT-1:0] q_c;

  // Stage 1 combinational: exact product and widened sum, each clamped to N bits.
  always_comb begin
    prod    = PRW'(a) * PRW'(b);
    mpy_sat = N'(sat_to(MAX_W'(prod), N));
    sum     = SMW'(c) + SMW'(mpy_sat);
    add_sat = N'(sat_to(MAX_W'(sum), N));
  end

  si_requant #(
    .N       (N),
    .N_OUT   (N_OUT),
    .M0_0Q32 (M0_0Q32),
    .SHIFT   (SHIFT)
  ) u_requant (
    .x (add_out),
    .q (q_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      mpy_out  <= '0;
      add_out  <= '0;
      s1_valid <= 1'b0;
      q_out    <= '0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s2_valid <= s1_valid;
      if (in_valid) begin
        mpy_out <= mpy_sat;
        add_out <= add_sat;
      end
      if (s1_valid) q_out <= q_c;
    end
  end

endmodule

// File: tb/tb_si_quant_arith.sv
// Directed self-checking bench for si_quant_arith with default parameters.
module tb_si_quant_arith;

  logic               clk = 1'b0;
  logic               reset;
  logic               in_valid;
  logic signed [31:0] a, b, c;
  logic signed [31:0] mpy_out, add_out;
  logic               s1_valid, s2_valid;
  logic signed [7:0]  q_out;

  int compared = 0;
  int mismatched = 0;

  si_quant_arith dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .a        (a),
    .b        (b),
    .c        (c),
    .mpy_out  (mpy_out),
    .add_out  (add_out),
    .s1_valid (s1_valid),
    .q_out    (q_out),
    .s2_valid (s2_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic signed [31:0] va, input logic signed [31:0] vb,
                       input logic signed [31:0] vc);
    in_valid = 1'b1;
    a = va;
    b = vb;
    c = vc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(3, -4, 100);
    step();
    step();
    compared++;
    if ({mpy_out, add_out, q_out, s1_valid, s2_valid} !== '0) begin
      $display("FAIL reset_outputs: got mpy=%0d add=%0d q=%0d v1=%b v2=%b, want all 0",
               mpy_out, add_out, q_out, s1_valid, s2_valid);
      mismatched++;
    end
    reset = 1'b0;
    step();
    compared++;
    if (mpy_out !== -32'sd12 || add_out !== 32'sd88 || s1_valid !== 1'b1 || s2_valid !== 1'b0) begin
      $display("FAIL first_s1: got mpy=%0d add=%0d v1=%b v2=%b, want -12 88 1 0",
               mpy_out, add_out, s1_valid, s2_valid);
      mismatched++;
    end
    in_valid = 1'b0;
    step();
    compared++;
    if (q_out !== 8'sd0 || s2_valid !== 1'b1 || s1_valid !== 1'b0) begin
      $display("FAIL first_s2: got q=%0d v2=%b v1=%b, want 0 1 0", q_out, s2_valid, s1_valid);
      mismatched++;
    end
  endtask

  task automatic test_basic();
    drive(100, 100, 0);
    step();
    compared++;
    if (mpy_out !== 32'sd10000 || add_out !== 32'sd10000) begin
      $display("FAIL basic_10k_s1: got mpy=%0d add=%0d, want 10000 10000", mpy_out, add_out);
      mismatched++;
    end
    drive(1000, 100, 0);
    step();
    compared++;
    if (q_out !== 8'sd4 || add_out !== 32'sd100000) begin
      $display("FAIL basic_10k_q: got q=%0d add=%0d, want q=4 add=100000", q_out, add_out);
      mismatched++;
    end
    in_valid = 1'b0;
    step();
    compared++;
    if (q_out !== 8'sd44) begin
      $display("FAIL basic_100k_q: got %0d, want 44", q_out);
      mismatched++;
    end
  endtask

  task automatic test_saturation();
    drive(65536, 65536, 0);
    step();
    compared++;
    if (mpy_out !== 32'sd2147483647 || add_out !== 32'sd2147483647) begin
      $display("FAIL sat_mpy: got mpy=%0d add=%0d, want 2147483647 both", mpy_out, add_out);
      mismatched++;
    end
    drive(1, 1, 32'sd2147483647);
    step();
    compared++;
    if (q_out !== 8'sd127) begin
      $display("FAIL sat_q_pos: got %0d, want 127", q_out);
      mismatched++;
    end
    compared++;
    if (add_out !== 32'sd2147483647 || mpy_out !== 32'sd1) begin
      $display("FAIL sat_add_nowrap: got add=%0d mpy=%0d, want 2147483647 1", add_out, mpy_out);
      mismatched++;
    end
    drive(32'sh8000_0000, 32'sh8000_0000, -1);
    step();
    compared++;
    if (mpy_out !== 32'sd2147483647 || add_out !== 32'sd2147483646) begin
      $display("FAIL sat_minmin: got mpy=%0d add=%0d, want 2147483647 2147483646",
               mpy_out, add_out);
      mismatched++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_negative();
    drive(-100, 100, 0);
    step();
    compared++;
    if (add_out !== -32'sd10000) begin
      $display("FAIL neg_10k_add: got %0d, want -10000", add_out);
      mismatched++;
    end
    drive(-1000, 1000, 0);
    step();
    compared++;
    if (q_out !== -8'sd4) begin
      $display("FAIL neg_10k_q: got %0d, want -4", q_out);
      mismatched++;
    end
    compared++;
    if (add_out !== -32'sd1000000) begin
      $display("FAIL neg_1m_add: got %0d, want -1000000", add_out);
      mismatched++;
    end
    drive(32'sh8000_0000, 1, -1);
    step();
    compared++;
    if (q_out !== -8'sd128) begin
      $display("FAIL neg_1m_q: got %0d, want -128", q_out);
      mismatched++;
    end
    compared++;
    if (add_out !== 32'sh8000_0000 || mpy_out !== 32'sh8000_0000) begin
      $display("FAIL neg_min_add: got add=%0d mpy=%0d, want -2147483648 both", add_out, mpy_out);
      mismatched++;
    end
    in_valid = 1'b0;
    step();
  endtask

  task automatic test_back_to_back();
    logic signed [31:0] va [4] = '{100, 1000, 200, -300};
    logic signed [7:0]  eq [4] = '{4, 44, 9, -13};
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(va[i], 100, 0);
      else in_valid = 1'b0;
      step();
      if (i >= 1 && i <= 4) begin
        compared++;
        if (q_out !== eq[i-1] || s2_valid !== 1'b1) begin
          $display("FAIL b2b_q%0d: got q=%0d v2=%b, want q=%0d v2=1",
                   i - 1, q_out, s2_valid, eq[i-1]);
          mismatched++;
        end
      end
      if (i == 4) begin
        compared++;
        if (s1_valid !== 1'b0 || add_out !== -32'sd30000) begin
          $display("FAIL hold_s1: got v1=%b add=%0d, want 0 -30000", s1_valid, add_out);
          mismatched++;
        end
      end
      if (i == 5) begin
        compared++;
        if (s2_valid !== 1'b0 || q_out !== -8'sd13 || mpy_out !== -32'sd30000) begin
          $display("FAIL hold_s2: got v2=%b q=%0d mpy=%0d, want 0 -13 -30000",
                   s2_valid, q_out, mpy_out);
          mismatched++;
        end
      end
    end
  endtask

  task automatic test_reset_midstream();
    drive(100, 100, 0);
    step();
    compared++;
    if (s1_valid !== 1'b1) begin
      $display("FAIL mid_pre: got v1=%b, want 1", s1_valid);
      mismatched++;
    end
    reset = 1'b1;
    step();
    compared++;
    if ({mpy_out, add_out, q_out, s1_valid, s2_valid} !== '0) begin
      $display("FAIL mid_reset: got mpy=%0d add=%0d q=%0d v1=%b v2=%b, want all 0",
               mpy_out, add_out, q_out, s1_valid, s2_valid);
      mismatched++;
    end
    reset = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      compared++;
      if (q_out !== 8'sd0 || s2_valid !== 1'b0) begin
        $display("FAIL mid_stale%0d: got q=%0d v2=%b, want 0 0", i, q_out, s2_valid);
        mismatched++;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    in_valid = 1'b0;
    a = '0;
    b = '0;
    c = '0;
    test_reset();
    test_basic();
    test_saturation();
    test_negative();
    test_back_to_back();
    test_reset_midstream();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/si_quant_arith.md
Name: si_quant_arith

Overview:
- Signed-integer arithmetic datapath for the neural-network MAC core: saturating multiply, saturating accumulate-add, and fixed-point requantization (downscale) to a narrow output word.
- Computes prod = a*b and sum = c + prod at full accumulator width N, then requantizes sum by real multiplier M = M0 * 2^-SHIFT to N_OUT bits.
- Two-stage registered pipeline; sits between the weight/value registers and the neuron output.

Parameters:
- N, 32, accumulator/operand width (two's complement).
- N_OUT, 8, requantized output width (two's complement).
- M0_0Q32, 1932735283, unsigned 0Q32 multiplier mantissa (value/2^32; default is 0.45).
- SHIFT, 10, extra right-shift exponent; M = M0_0Q32 / 2^(32+SHIFT).

Ports:
- clk  input  1  clock, all state on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operands a/b/c valid this cycle.
- a  input  N  signed multiplicand.
- b  input  N  signed multiplier.
- c  input  N  signed addend (accumulator state; 0 to start a new sum).
- mpy_out  output  N  signed saturated a*b, stage 1.
- add_out  output  N  signed saturated c + sat(a*b), stage 1.
- s1_valid  output  1  mpy_out/add_out valid.
- q_out  output  N_OUT  requantized add_out, stage 2.
- s2_valid  output  1  q_out valid.

Behaviour:
- Interface: reset is synchronous, active-high; clock is clk.
- Reset: all output registers and both valid flags are cleared to 0 on the cycle after reset is sampled high. Reset overrides in_valid. In-flight data is discarded.
- Stage 1 (latency 1):
  - When in_valid=1, register mpy_out = SAT_N(a*b) using the full 2N-bit signed product.
  - Also register add_out = SAT_N(c + SAT_N(a*b)) using an (N+1)-bit signed sum.
  - s1_valid <= in_valid.
  - When in_valid=0, mpy_out/add_out hold their values.
- Stage 2 (latency 2 from inputs):
  - When s1_valid=1, compute p = add_out * M0_0Q32 with M0 zero-extended, as an exact signed (N+33)-bit product.
  - Round: r = (p + 2^(31+SHIFT)) >>> (32+SHIFT), arithmetic shift. This is round-half-up toward +inf.
  - Register q_out <= SAT_NOUT(r); s2_valid <= s1_valid.
  - When s1_valid=0, q_out holds.
- SAT_W(x): clamp to [-2^(W-1), 2^(W-1)-1]. No wrap-around is permitted anywhere.
- Back-to-back in_valid every cycle is fully pipelined: throughput is 1 result per cycle.
- No backpressure; no handshake beyond the valid flags.
- Edge operands:
  - a = b = -2^(N-1) saturates mpy_out to 2^(N-1)-1.
  - add_out then saturates as needed.
- Parameter legality: 0 <= SHIFT <= 31 and N_OUT <= N. This is checked with an elaboration-time assertion.

Decomposition:
- Package si_arith_pkg holds:
  - saturate function (width-parameterized via max/min constants);
  - rounding-constant helper;
  - default M0/SHIFT constants.
- One sub-module, si_requant: combinational downscale (multiply by M0, round, shift, saturate), parameterized N, N_OUT, M0_0Q32, SHIFT. It is instantiated in stage 2.
- Multiply and add stay inline in the top.

Test Plan:
- Defaults. Reset asserted 2 cycles with in_valid=1 -> all outputs 0, s1_valid = s2_valid = 0. After release, a=3, b=-4, c=100 -> mpy_out=-12, add_out=88 at +1; q_out=0 at +2.
- a=100, b=100, c=0 -> mpy_out=10000, add_out=10000, q_out=4. Then a=1000, b=100, c=0 -> add_out=100000, q_out=44 (43.95 rounded).
- Saturation:
  - a=65536, b=65536, c=0 -> mpy_out=2147483647, add_out=2147483647, q_out=127.
  - a=1, b=1, c=2147483647 -> add_out=2147483647 (no wrap).
- Negative path:
  - a=-100, b=100, c=0 -> add_out=-10000, q_out=-4.
  - a=-1000, b=1000, c=0 -> add_out=-1000000, q_out=-128 (saturated).
  - a=-2147483648, b=1, c=-1 -> add_out=-2147483648.
- Pipeline and hold:
  - Drive 4 consecutive valid vectors -> q_out sequence appears on 4 consecutive cycles, each 2 cycles after its input.
  - Then in_valid=0 -> outputs hold, s2_valid drops one cycle after s1_valid.
- Reset mid-stream: assert reset while s1_valid=1 -> next cycle all outputs and valids are 0, and no stale q_out is emitted afterwards.
